// File: rtl/ysyx_24110006_pkg.sv
// Shared definitions for the multi-cycle core sequencer and the units it drives.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
//
// Contents: FSM state encodings, major opcode constants, IDU CSR type codes,
// and helpers that classify a decoded opcode for the writeback path.
package ysyx_24110006_pkg;

  // Sequencer states; the encodings are visible on o_state / o_err_stage.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6,
    ST_ERR    = 3'd7
  } stage_e;

  // Major opcodes the sequencer has to tell apart.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // CSR type codes produced by the IDU for SYSTEM instructions.
  localparam logic [2:0] CSR_MRET  = 3'b000;
  localparam logic [2:0] CSR_CSRW  = 3'b001;
  localparam logic [2:0] CSR_ECALL = 3'b011;

  // Only loads and stores visit the MEM stage.
  function automatic logic op_uses_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  // Register-file write policy at writeback. Stores and branches never write;
  // among SYSTEM instructions only a CSR write returns a value to rd.
  function automatic logic op_writes_rf(input logic [6:0] op, input logic [2:0] csr_t);
    logic wen;
    wen = 1'b1;
    if ((op == OP_STORE) || (op == OP_BRANCH)) begin
      wen = 1'b0;
    end else if (op == OP_SYSTEM) begin
      case (csr_t)
        CSR_CSRW:            wen = 1'b1;
        CSR_MRET, CSR_ECALL: wen = 1'b0;
        default:             wen = 1'b0;
      endcase
    end
    return wen;
  endfunction

endpackage

// File: rtl/ysyx_24110006_stage_wdt.sv
// Per-stage watchdog: flags a unit that has not answered within TIMEOUT_CYCLES.
// Latency: o_expire is combinational from the counter, asserted in the TIMEOUT_CYCLES-th enabled cycle.
// Backpressure: none; the caller decides whether a same-cycle done overrides expiry.
//
// Ports:
//   i_clock, i_reset_n : core clock, asynchronous active-low reset
//   i_clear            : restart the count (asserted on every state change)
//   i_enable           : current state is one that waits on a unit
//   o_expire           : this enabled cycle is the last one allowed
// TIMEOUT_CYCLES = 0 builds no counter and never expires.
module ysyx_24110006_stage_wdt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      logic unused_wdt_inputs;
      assign unused_wdt_inputs = ^{i_clock, i_reset_n, i_clear, i_enable};
      assign o_expire = 1'b0;
    end else begin : g_on
      localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
      // cnt_q holds the number of completed cycles in the current state, so
      // the cycle in which it equals LAST is the TIMEOUT_CYCLES-th cycle.
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
      localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);

      logic [CW-1:0] cnt_q;

      always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
          cnt_q <= '0;
        end else if (i_clear) begin
          cnt_q <= '0;
        end else if (i_enable && (cnt_q != SAT)) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end

      assign o_expire = i_enable && (cnt_q >= LAST);
    end
  endgenerate

endmodule

// File: rtl/ysyx_24110006_stage_seq.sv
// Multi-cycle core sequencer: pulses IFU/IDU/EXU/LSU starts in order and strobes writeback.
// Latency: one cycle per stage minimum (FETCH, DECODE, EXEC, [MEM], WB); every output is registered.
// Backpressure: each stage holds until its unit's valid; a per-stage watchdog sends a hung unit to ERR.
//
// Ports:
//   i_clock, i_reset_n        : core clock, asynchronous active-low reset
//   i_ifu/idu/exu/lsu_valid   : per-unit done, honoured only in that unit's own state
//   i_op, i_csr_t             : decoded opcode / CSR type, stable from DECODE done through WB
//   i_halt                    : halt request, sampled in WB
//   o_ifu_req/o_idu_start/o_exu_start/o_lsu_start : one-cycle start pulses on state entry
//   o_rf_wen, o_pc_wen, o_retire : writeback strobes, WB cycle only
//   o_state, o_busy           : current state encoding, state is not IDLE/HALT/ERR
//   o_timeout_err, o_err_stage: sticky watchdog error and the state it fired in
//   o_cycle_cnt, o_inst_cnt   : performance counters, built only with YSYX_24110006_PERF_CNT_EN
module ysyx_24110006_stage_seq
  import ysyx_24110006_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 32
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_ifu_valid,
  input  logic             i_idu_valid,
  input  logic [6:0]       i_op,
  input  logic [2:0]       i_csr_t,
  input  logic             i_exu_valid,
  input  logic             i_lsu_valid,
  input  logic             i_halt,
  output logic             o_ifu_req,
  output logic             o_idu_start,
  output logic             o_exu_start,
  output logic             o_lsu_start,
  output logic             o_rf_wen,
  output logic             o_pc_wen,
  output logic             o_retire,
  output logic [2:0]       o_state,
  output logic             o_busy,
  output logic             o_timeout_err,
  output logic [2:0]       o_err_stage,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic [CNT_W-1:0] o_inst_cnt
);

  stage_e     state_q, state_d;
  logic       unit_done;
  logic       wdt_clear, wdt_enable, wdt_expire, wdt_fire;

  logic       ifu_req_q, ifu_req_d;
  logic       idu_start_q, idu_start_d;
  logic       exu_start_q, exu_start_d;
  logic       lsu_start_q, lsu_start_d;
  logic       wb_q, wb_d;
  logic       rf_wen_q, rf_wen_d;
  logic       busy_q, busy_d;
  logic       terr_q, terr_d;
  logic [2:0] err_stage_q, err_stage_d;

  // The unit that owns the current state; dones from other units are ignored.
  always_comb begin
    unit_done = 1'b0;
    case (state_q)
      ST_FETCH:  unit_done = i_ifu_valid;
      ST_DECODE: unit_done = i_idu_valid;
      ST_EXEC:   unit_done = i_exu_valid;
      ST_MEM:    unit_done = i_lsu_valid;
      default:   unit_done = 1'b0;
    endcase
  end

  // Next state and the next value of every registered output.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  if (i_ifu_valid) state_d = ST_DECODE;
      ST_DECODE: if (i_idu_valid) state_d = ST_EXEC;
      ST_EXEC:   if (i_exu_valid) state_d = op_uses_mem(i_op) ? ST_MEM : ST_WB;
      ST_MEM:    if (i_lsu_valid) state_d = ST_WB;
      ST_WB:     state_d = i_halt ? ST_HALT : ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      ST_ERR:    state_d = ST_ERR;
      default:   state_d = ST_ERR;
    endcase

    // A done arriving in the limit cycle wins over the watchdog.
    wdt_fire = wdt_expire && !unit_done;
    if (wdt_fire) begin
      state_d = ST_ERR;
    end

    // Every transition changes state, so "next differs from current" marks
    // the first cycle of a stage, including re-entry on the next instruction.
    ifu_req_d   = (state_d == ST_FETCH)  && (state_q != ST_FETCH);
    idu_start_d = (state_d == ST_DECODE) && (state_q != ST_DECODE);
    exu_start_d = (state_d == ST_EXEC)   && (state_q != ST_EXEC);
    lsu_start_d = (state_d == ST_MEM)    && (state_q != ST_MEM);
    wb_d        = (state_d == ST_WB);
    rf_wen_d    = wb_d && op_writes_rf(i_op, i_csr_t);
    busy_d      = !((state_d == ST_IDLE) || (state_d == ST_HALT) || (state_d == ST_ERR));

    terr_d      = terr_q || wdt_fire;
    err_stage_d = wdt_fire ? state_q : err_stage_q;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q     <= ST_IDLE;
      ifu_req_q   <= 1'b0;
      idu_start_q <= 1'b0;
      exu_start_q <= 1'b0;
      lsu_start_q <= 1'b0;
      wb_q        <= 1'b0;
      rf_wen_q    <= 1'b0;
      busy_q      <= 1'b0;
      terr_q      <= 1'b0;
      err_stage_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      ifu_req_q   <= ifu_req_d;
      idu_start_q <= idu_start_d;
      exu_start_q <= exu_start_d;
      lsu_start_q <= lsu_start_d;
      wb_q        <= wb_d;
      rf_wen_q    <= rf_wen_d;
      busy_q      <= busy_d;
      terr_q      <= terr_d;
      err_stage_q <= err_stage_d;
    end
  end

  // Only the unit-waiting states are timed; the count restarts on each entry.
  assign wdt_clear  = (state_d != state_q);
  assign wdt_enable = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                      (state_q == ST_EXEC)  || (state_q == ST_MEM);

  ysyx_24110006_stage_wdt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdt (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_clear  (wdt_clear),
    .i_enable (wdt_enable),
    .o_expire (wdt_expire)
  );

  assign o_state       = state_q;
  assign o_ifu_req     = ifu_req_q;
  assign o_idu_start   = idu_start_q;
  assign o_exu_start   = exu_start_q;
  assign o_lsu_start   = lsu_start_q;
  assign o_rf_wen      = rf_wen_q;
  assign o_pc_wen      = wb_q;
  assign o_retire      = wb_q;
  assign o_busy        = busy_q;
  assign o_timeout_err = terr_q;
  assign o_err_stage   = err_stage_q;

`ifdef YSYX_24110006_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt_q;
  logic [CNT_W-1:0] inst_cnt_q;

  // inst_cnt steps on the same edge that raises o_retire.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cycle_cnt_q <= '0;
      inst_cnt_q  <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_q + 1'b1;
      if (wb_d) begin
        inst_cnt_q <= inst_cnt_q + 1'b1;
      end
    end
  end

  assign o_cycle_cnt = cycle_cnt_q;
  assign o_inst_cnt  = inst_cnt_q;
`else
  assign o_cycle_cnt = '0;
  assign o_inst_cnt  = '0;
`endif

endmodule

// File: tb/tb_ysyx_24110006_stage_seq.sv
// Bench for the stage sequencer: a directed table of instructions, hand-written
// watchdog / halt / reset sequences, and a random instruction stream whose
// expected per-cycle trace is derived from stage delays and opcode rules.
module tb_ysyx_24110006_stage_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        i_ifu_valid = 1'b0, i_idu_valid = 1'b0, i_exu_valid = 1'b0, i_lsu_valid = 1'b0;
  logic        i_halt = 1'b0;
  logic [6:0]  i_op = 7'd0;
  logic [2:0]  i_csr_t = 3'd0;

  logic        o_ifu_req, o_idu_start, o_exu_start, o_lsu_start;
  logic        o_rf_wen, o_pc_wen, o_retire, o_busy, o_timeout_err;
  logic [2:0]  o_state, o_err_stage;
  logic [31:0] o_cycle_cnt, o_inst_cnt;

  logic        z_ifu_req, z_idu_start, z_exu_start, z_lsu_start;
  logic        z_rf_wen, z_pc_wen, z_retire, z_busy, z_timeout_err;
  logic [2:0]  z_state, z_err_stage;
  logic [31:0] z_cycle_cnt, z_inst_cnt;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ncyc;

  always #5 clk = ~clk;

  ysyx_24110006_stage_seq #(.TIMEOUT_CYCLES(8), .CNT_W(32)) u_dut (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_ifu_valid(i_ifu_valid), .i_idu_valid(i_idu_valid), .i_op(i_op), .i_csr_t(i_csr_t),
    .i_exu_valid(i_exu_valid), .i_lsu_valid(i_lsu_valid), .i_halt(i_halt),
    .o_ifu_req(o_ifu_req), .o_idu_start(o_idu_start), .o_exu_start(o_exu_start),
    .o_lsu_start(o_lsu_start), .o_rf_wen(o_rf_wen), .o_pc_wen(o_pc_wen), .o_retire(o_retire),
    .o_state(o_state), .o_busy(o_busy), .o_timeout_err(o_timeout_err), .o_err_stage(o_err_stage),
    .o_cycle_cnt(o_cycle_cnt), .o_inst_cnt(o_inst_cnt)
  );

  // Same stimulus, watchdog disabled.
  ysyx_24110006_stage_seq #(.TIMEOUT_CYCLES(0), .CNT_W(32)) u_dut_nowdt (
    .i_clock(clk), .i_reset_n(rst_n),
    .i_ifu_valid(i_ifu_valid), .i_idu_valid(i_idu_valid), .i_op(i_op), .i_csr_t(i_csr_t),
    .i_exu_valid(i_exu_valid), .i_lsu_valid(i_lsu_valid), .i_halt(i_halt),
    .o_ifu_req(z_ifu_req), .o_idu_start(z_idu_start), .o_exu_start(z_exu_start),
    .o_lsu_start(z_lsu_start), .o_rf_wen(z_rf_wen), .o_pc_wen(z_pc_wen), .o_retire(z_retire),
    .o_state(z_state), .o_busy(z_busy), .o_timeout_err(z_timeout_err), .o_err_stage(z_err_stage),
    .o_cycle_cnt(z_cycle_cnt), .o_inst_cnt(z_inst_cnt)
  );

  // Bench-side count of clock edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ncyc <= 0;
    else        ncyc <= ncyc + 1;
  end

  typedef struct {
    logic [6:0] op;
    logic [2:0] csr;
    int         df, dd, de, dm;
    logic       mem;
    logic       rf;
  } vec_t;

  vec_t tbl [10];
  logic [6:0] ops [7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Packed view: {state, ifu, idu, exu, lsu, rf, pc, retire, busy, terr, err_stage}
  function automatic logic [14:0] mk(input logic [2:0] st, input logic ifu, idu, exu, lsu,
                                     input logic rf, pc, ret, busy, terr, input logic [2:0] es);
    return {st, ifu, idu, exu, lsu, rf, pc, ret, busy, terr, es};
  endfunction

  function automatic logic [14:0] outs();
    return {o_state, o_ifu_req, o_idu_start, o_exu_start, o_lsu_start,
            o_rf_wen, o_pc_wen, o_retire, o_busy, o_timeout_err, o_err_stage};
  endfunction

  // Reference rules, straight from the opcode table.
  function automatic logic ref_mem(input logic [6:0] op);
    return (op == 7'b0000011) || (op == 7'b0100011);
  endfunction

  function automatic logic ref_rf(input logic [6:0] op, input logic [2:0] csr);
    if (op == 7'b0100011 || op == 7'b1100011) return 1'b0;
    if (op == 7'b1110011) return csr == 3'b001;
    return 1'b1;
  endfunction

  // Random noise on every done line and halt, then the owning unit's done.
  task automatic drive(input int stg, input bit done);
    i_ifu_valid = 1'($urandom);
    i_idu_valid = 1'($urandom);
    i_exu_valid = 1'($urandom);
    i_lsu_valid = 1'($urandom);
    i_halt      = 1'($urandom);
    case (stg)
      1: i_ifu_valid = done;
      2: i_idu_valid = done;
      3: i_exu_valid = done;
      4: i_lsu_valid = done;
      default: ;
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    {i_ifu_valid, i_idu_valid, i_exu_valid, i_lsu_valid, i_halt} = '0;
    i_op = 7'd0;
    i_csr_t = 3'd0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 64'(outs()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    chk("reset_cnts", {o_cycle_cnt, o_inst_cnt}, 64'd0);
    rst_n = 1'b1;
  endtask

  // One stage lasting d+1 cycles, done returned in its last cycle.
  task automatic run_stage(input string nm, input int stg, input int d);
    for (int c = 0; c <= d; c++) begin
      @(negedge clk);
      chk(nm, 64'(outs()), 64'(mk(3'(stg), stg == 1 && c == 0, stg == 2 && c == 0,
                                  stg == 3 && c == 0, stg == 4 && c == 0, 0, 0, 0, 1, 0, 0)));
      drive(stg, c == d);
    end
  endtask

  task automatic run_inst(input string nm, input logic [6:0] op, input logic [2:0] csr,
                          input int df, dd, de, dm, input logic halt,
                          input logic mem, input logic rf);
    i_op = op;
    i_csr_t = csr;
    run_stage(nm, 1, df);
    run_stage(nm, 2, dd);
    run_stage(nm, 3, de);
    if (mem) run_stage(nm, 4, dm);
    @(negedge clk);
    chk({nm, "_wb"}, 64'(outs()), 64'(mk(5, 0, 0, 0, 0, rf, 1, 1, 1, 0, 0)));
    drive(5, 1'b0);
    i_halt = halt;
  endtask

  task automatic check_halt(input string nm);
    repeat (3) begin
      @(negedge clk);
      chk(nm, 64'(outs()), 64'(mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
      drive(0, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{7'b0110011, 3'b000, 0, 0, 0, 0, 1'b0, 1'b1}; // ADD, all dones in entry cycle
    tbl[1] = '{7'b0000011, 3'b000, 0, 0, 0, 3, 1'b1, 1'b1}; // load, LSU 3 cycles late
    tbl[2] = '{7'b0100011, 3'b000, 1, 2, 0, 0, 1'b1, 1'b0}; // store
    tbl[3] = '{7'b1100011, 3'b000, 0, 0, 2, 0, 1'b0, 1'b0}; // branch
    tbl[4] = '{7'b1110011, 3'b001, 0, 1, 0, 0, 1'b0, 1'b1}; // CSRW
    tbl[5] = '{7'b1110011, 3'b011, 0, 0, 0, 0, 1'b0, 1'b0}; // ECALL
    tbl[6] = '{7'b1110011, 3'b000, 0, 0, 0, 1, 1'b0, 1'b0}; // MRET
    tbl[7] = '{7'b0010011, 3'b000, 0, 0, 7, 0, 1'b0, 1'b1}; // EXU done in 8th cycle
    tbl[8] = '{7'b0000011, 3'b000, 0, 0, 0, 7, 1'b1, 1'b1}; // LSU done in 8th cycle
    tbl[9] = '{7'b0110011, 3'b000, 7, 0, 0, 0, 1'b0, 1'b1}; // IFU done in 8th cycle
    ops = '{7'b0110011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1110011, 7'b0010011, 7'b1101111};

    // Directed table, back to back, ending in a halt.
    do_reset();
    @(negedge clk);
    chk("idle_after_release", 64'(outs()), 64'(mk(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0)));
    rst_n = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_inst($sformatf("tbl%0d", i), tbl[i].op, tbl[i].csr, tbl[i].df, tbl[i].dd,
               tbl[i].de, tbl[i].dm, 1'b0, tbl[i].mem, tbl[i].rf);
    end
    run_inst("halt_inst", 7'b0110011, 3'b000, 0, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    check_halt("halt");

    // EXU never answers: ERR after 8 EXEC cycles; the unguarded copy keeps waiting.
    do_reset();
    i_op = 7'b0110011;
    run_stage("wdt_fetch", 1, 0);
    run_stage("wdt_decode", 2, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("wdt_exec", 64'(outs()), 64'(mk(3, 0, 0, c == 0, 0, 0, 0, 0, 1, 0, 0)));
      drive(3, 1'b0);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("wdt_err", 64'(outs()), 64'(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3)));
      chk("wdt_disabled", 64'({z_state, z_timeout_err}), 64'({3'd3, 1'b0}));
      drive(0, 1'b0);
      i_exu_valid = 1'b0;
    end

    // Reset pulse in the middle of EXEC aborts at once.
    do_reset();
    i_op = 7'b0110011;
    run_stage("arst_fetch", 1, 0);
    run_stage("arst_decode", 2, 0);
    @(negedge clk);
    chk("arst_exec", 64'(outs()), 64'(mk(3, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0)));
    i_exu_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("arst_outs", 64'(outs()), 64'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)));
    chk("arst_cnts", {o_cycle_cnt, o_inst_cnt}, 64'd0);

    // Random instruction stream against the opcode-rule model.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      logic [6:0] op;
      logic [2:0] csr;
      op  = ops[$urandom_range(0, 6)];
      csr = 3'($urandom);
      run_inst($sformatf("rnd%0d_op%b", n, op), op, csr, $urandom_range(0, 5), $urandom_range(0, 5),
               $urandom_range(0, 5), $urandom_range(0, 5), n == 39, ref_mem(op), ref_rf(op, csr));
    end
    check_halt("rnd_halt");

    // Ten ADDs then halt: performance counters.
    do_reset();
    for (int n = 0; n < 10; n++) begin
      run_inst("perf_add", 7'b0110011, 3'b000, 0, 0, 0, 0, n == 9, 1'b0, 1'b1);
    end
    check_halt("perf_halt");
`ifdef YSYX_24110006_PERF_CNT_EN
    chk("perf_inst_cnt", 64'(o_inst_cnt), 64'd10);
    chk("perf_cycle_cnt", 64'(o_cycle_cnt), 64'(ncyc));
`else
    chk("perf_inst_cnt_off", 64'(o_inst_cnt), 64'd0);
    chk("perf_cycle_cnt_off", 64'(o_cycle_cnt), 64'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
